// File: rtl/pc_stack_if.sv
// Control strobes and observed state of the program counter / return stack.
interface pc_stack_if #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 3
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [2:0]        cycle;
  logic              pcLoad;
  logic              pcPush;
  logic              pcPop;
  logic [ADDR_W-1:0] pcNew;
  logic              clrFlags;
  logic [ADDR_W-1:0] pcAddr;
  logic [3:0]        pcNibble;
  logic [LVL_W-1:0]  stackLevel;
  logic              stackOverflow;
  logic              stackUnderflow;

  modport master (
    output cycle, pcLoad, pcPush, pcPop, pcNew, clrFlags,
    input  pcAddr, pcNibble, stackLevel, stackOverflow, stackUnderflow
  );

  modport slave (
    input  cycle, pcLoad, pcPush, pcPop, pcNew, clrFlags,
    output pcAddr, pcNibble, stackLevel, stackOverflow, stackUnderflow
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with circular return-address stack; state updates one edge after a strobe,
// pcNibble is combinational. No backpressure: strobes are sampled every edge and always accepted.
module pc_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 3,
  parameter int INC_CYCLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);
  localparam int NIB     = ADDR_W / 4;
  localparam int NIB_SEL = (NIB < 8) ? NIB : 8;
  localparam int LVL_W   = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_wp_inc;
  logic [PTR_W-1:0]  w_wp_dec;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [3:0]        w_nibble;

  always_comb begin
    w_wp_inc = (r_wp == PTR_W'(STACK_DEPTH - 1)) ? '0 : r_wp + 1'b1;
    w_wp_dec = (r_wp == '0) ? PTR_W'(STACK_DEPTH - 1) : r_wp - 1'b1;
  end

  assign w_full    = (r_level == LVL_W'(STACK_DEPTH));
  assign w_empty   = (r_level == '0);
  // A pop on the same edge masks the push entirely, so it cannot overflow.
  assign w_unf_set = bus.pcPop & w_empty;
  assign w_ovf_set = bus.pcPush & ~bus.pcPop & w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_wp    <= '0;
      r_level <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (bus.pcPop) begin
      r_pc <= r_stack[w_wp_dec];
      r_wp <= w_wp_dec;
      if (!w_empty) r_level <= r_level - 1'b1;
    end else if (bus.pcPush) begin
      r_stack[r_wp] <= r_pc;
      r_pc          <= bus.pcNew;
      r_wp          <= w_wp_inc;
      if (!w_full) r_level <= r_level + 1'b1;
    end else if (bus.pcLoad) begin
      r_pc <= bus.pcNew;
    end else if (bus.cycle == 3'(INC_CYCLE)) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.clrFlags);
      r_unf <= w_unf_set | (r_unf & ~bus.clrFlags);
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NIB_SEL; i++) begin
      if (bus.cycle == 3'(i)) w_nibble = r_pc[i*4 +: 4];
    end
  end

  assign bus.pcAddr         = r_pc;
  assign bus.pcNibble       = w_nibble;
  assign bus.stackLevel     = r_level;
  assign bus.stackOverflow  = r_ovf;
  assign bus.stackUnderflow = r_unf;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: the driver queues expected state, a monitor drains and compares.
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst;

  pc_stack_if #(.ADDR_W(12), .STACK_DEPTH(3)) bus ();

  pc_stack #(.ADDR_W(12), .STACK_DEPTH(3), .INC_CYCLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          c_state;
    logic [11:0] pc;
    logic [1:0]  lvl;
    logic        ovf;
    logic        unf;
    bit          c_nib;
    logic [3:0]  nib;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  event chk_ev;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: drains on every falling edge, or immediately on chk_ev.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.c_state) begin
          cmp({e.name, " pc"},  32'(bus.pcAddr),         32'(e.pc));
          cmp({e.name, " lvl"}, 32'(bus.stackLevel),     32'(e.lvl));
          cmp({e.name, " ovf"}, 32'(bus.stackOverflow),  32'(e.ovf));
          cmp({e.name, " unf"}, 32'(bus.stackUnderflow), 32'(e.unf));
        end
        if (e.c_nib) cmp({e.name, " nib"}, 32'(bus.pcNibble), 32'(e.nib));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

  task automatic drv(input logic [2:0] c, input logic ld, input logic psh, input logic pp,
                     input logic [11:0] nw, input logic clr);
    bus.cycle    = c;
    bus.pcLoad   = ld;
    bus.pcPush   = psh;
    bus.pcPop    = pp;
    bus.pcNew    = nw;
    bus.clrFlags = clr;
  endtask

  function automatic exp_t mk_state(input string nm, input logic [11:0] pc, input logic [1:0] lvl,
                                    input logic o, input logic u);
    exp_t e;
    e.name = nm; e.c_state = 1'b1; e.pc = pc; e.lvl = lvl; e.ovf = o; e.unf = u;
    e.c_nib = 1'b0; e.nib = 4'h0;
    return e;
  endfunction

  // Expected state after the next rising edge; strobes are dropped afterwards.
  task automatic state_chk(input string nm, input logic [11:0] pc, input logic [1:0] lvl,
                           input logic o, input logic u);
    @(posedge clk);
    #1;
    sb.push_back(mk_state(nm, pc, lvl, o, u));
    bus.pcLoad = 1'b0; bus.pcPush = 1'b0; bus.pcPop = 1'b0; bus.clrFlags = 1'b0;
  endtask

  task automatic nib_chk(input string nm, input logic [3:0] nib);
    exp_t e;
    e = mk_state(nm, 12'h0, 2'd0, 1'b0, 1'b0);
    e.c_state = 1'b0; e.c_nib = 1'b1; e.nib = nib;
    sb.push_back(e);
  endtask

  // Action on a cycle value that never increments.
  task automatic act(input string nm, input logic ld, input logic psh, input logic pp,
                     input logic [11:0] nw, input logic clr, input logic [11:0] pc,
                     input logic [1:0] lvl, input logic o, input logic u);
    drv(3'd5, ld, psh, pp, nw, clr);
    state_chk(nm, pc, lvl, o, u);
  endtask

  initial begin
    logic [11:0] m_pc;
    rst = 1'b1;
    drv(3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    #2;
    sb.push_back(mk_state("reset", 12'h000, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    #2 rst = 1'b0;

    // Free-running frames: PC moves only on the edge sampled with cycle 2.
    m_pc = 12'h000;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 8; c++) begin
        drv(3'(c), 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        if (c < 3) nib_chk($sformatf("t1 f%0d c%0d", f, c), (f == 1 && c == 0) ? 4'h1 : 4'h0);
        if (c == 2) m_pc = m_pc + 12'h1;
        state_chk($sformatf("t1 f%0d c%0d", f, c), m_pc, 2'd0, 1'b0, 1'b0);
      end
    end

    drv(3'd0, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0);
    state_chk("t2 load", 12'hFFF, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c < 8; c++) begin
      drv(3'(c), 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      if (c == 1) nib_chk("t2 nib1", 4'hF);
      state_chk($sformatf("t2 c%0d", c), (c >= 2) ? 12'h000 : 12'hFFF, 2'd0, 1'b0, 1'b0);
    end

    act("t3 load",  1'b1, 1'b0, 1'b0, 12'h010, 1'b0, 12'h010, 2'd0, 1'b0, 1'b0);
    act("t3 push1", 1'b0, 1'b1, 1'b0, 12'h100, 1'b0, 12'h100, 2'd1, 1'b0, 1'b0);
    act("t3 push2", 1'b0, 1'b1, 1'b0, 12'h200, 1'b0, 12'h200, 2'd2, 1'b0, 1'b0);
    act("t3 push3", 1'b0, 1'b1, 1'b0, 12'h300, 1'b0, 12'h300, 2'd3, 1'b0, 1'b0);
    act("t3 pop1",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h200, 2'd2, 1'b0, 1'b0);
    act("t3 pop2",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h100, 2'd1, 1'b0, 1'b0);
    act("t3 pop3",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h010, 2'd0, 1'b0, 1'b0);

    act("t4 load",  1'b1, 1'b0, 1'b0, 12'h005, 1'b0, 12'h005, 2'd0, 1'b0, 1'b0);
    act("t4 pushA", 1'b0, 1'b1, 1'b0, 12'h00A, 1'b0, 12'h00A, 2'd1, 1'b0, 1'b0);
    act("t4 pushB", 1'b0, 1'b1, 1'b0, 12'h00B, 1'b0, 12'h00B, 2'd2, 1'b0, 1'b0);
    act("t4 pushC", 1'b0, 1'b1, 1'b0, 12'h00C, 1'b0, 12'h00C, 2'd3, 1'b0, 1'b0);
    act("t4 pushD", 1'b0, 1'b1, 1'b0, 12'h00D, 1'b0, 12'h00D, 2'd3, 1'b1, 1'b0);
    act("t4 pop1",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h00C, 2'd2, 1'b1, 1'b0);
    act("t4 pop2",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h00B, 2'd1, 1'b1, 1'b0);
    act("t4 pop3",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h00A, 2'd0, 1'b1, 1'b0);
    act("t4 pop4",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h00C, 2'd0, 1'b1, 1'b1);
    act("t4 clr",   1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h00C, 2'd0, 1'b0, 1'b0);
    // Underflow set and clear on the same edge: set wins.
    act("t4 popclr", 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 12'h00B, 2'd0, 1'b0, 1'b1);
    act("t4 clr2",  1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'h00B, 2'd0, 1'b0, 1'b0);

    act("t5 load",  1'b1, 1'b0, 1'b0, 12'h020, 1'b0, 12'h020, 2'd0, 1'b0, 1'b0);
    act("t5 push",  1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 12'h040, 2'd1, 1'b0, 1'b0);
    drv(3'd2, 1'b1, 1'b1, 1'b1, 12'h777, 1'b0);
    state_chk("t5 all3", 12'h020, 2'd0, 1'b0, 1'b0);
    drv(3'd2, 1'b1, 1'b0, 1'b0, 12'hABC, 1'b0);
    state_chk("t5 ldc2", 12'hABC, 2'd0, 1'b0, 1'b0);
    drv(3'd2, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    state_chk("t5 inc",  12'hABD, 2'd0, 1'b0, 1'b0);

    act("t6 pop0",  1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h00A, 2'd0, 1'b0, 1'b1);
    act("t6 push1", 1'b0, 1'b1, 1'b0, 12'h111, 1'b0, 12'h111, 2'd1, 1'b0, 1'b1);
    act("t6 push2", 1'b0, 1'b1, 1'b0, 12'h222, 1'b0, 12'h222, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    sb.push_back(mk_state("t6 async rst", 12'h000, 2'd0, 1'b0, 1'b0));
    -> chk_ev;
    #1 rst = 1'b0;
    act("t6 pop",   1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 2'd0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    cmp("queue drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
